// File: rtl/mdu_responder.sv
// Multiply/divide responder: latches operands on start, runs a fixed-latency mul/div and owns HI/LO.
// Optional MDU_EARLY_DONE_EN: zero-operand multiplies and zero-divisor divides finish after one busy cycle.
module mdu_responder #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] operand1,
   input  logic [31:0] operand2,
   input  logic [2:0]  operation,
   input  logic        start,
   output logic        busy,
   output logic [31:0] data_read
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d;
   logic [1:0]      kind_q, kind_d;
   logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic            early_c;
   logic            sgn_div_c;
   logic [2*DW-1:0] prod_c;
   logic [DW-1:0]   mag1_c, mag2_c, div2_c, uq_c, ur_c;
   logic [DW-1:0]   res_hi_c, res_lo_c;

   // Zero-operand shortcut, judged on the operands being captured this cycle
   always_comb begin
`ifdef MDU_EARLY_DONE_EN
      early_c = operation[1] ? (operand2 == '0) : ((operand1 == '0) || (operand2 == '0));
`else
      early_c = 1'b0;
`endif
   end

   // Result datapath; signed divide works on magnitudes so INT_MIN / -1 needs no special case
   always_comb begin
      sgn_div_c = ~kind_q[0];
      if (kind_q[0])
         prod_c = {{DW{1'b0}}, op1_q} * {{DW{1'b0}}, op2_q};
      else
         prod_c = $signed({{DW{op1_q[DW-1]}}, op1_q}) * $signed({{DW{op2_q[DW-1]}}, op2_q});
      mag1_c = (sgn_div_c && op1_q[DW-1]) ? -op1_q : op1_q;
      mag2_c = (sgn_div_c && op2_q[DW-1]) ? -op2_q : op2_q;
      div2_c = (mag2_c == '0) ? DW'(1) : mag2_c;
      uq_c   = mag1_c / div2_c;
      ur_c   = mag1_c % div2_c;
      if (!kind_q[1]) begin
         res_hi_c = prod_c[2*DW-1:DW];
         res_lo_c = prod_c[DW-1:0];
      end else if (op2_q == '0) begin
         res_hi_c = op1_q;
         res_lo_c = '1;
      end else begin
         res_lo_c = (sgn_div_c && (op1_q[DW-1] ^ op2_q[DW-1])) ? -uq_c : uq_c;
         res_hi_c = (sgn_div_c && op1_q[DW-1]) ? -ur_c : ur_c;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      kind_d  = kind_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (operation)
                  3'b010: hi_d = operand1;
                  3'b011: lo_d = operand1;
                  3'b100, 3'b101, 3'b110, 3'b111: begin
                     op1_d   = operand1;
                     op2_d   = operand2;
                     kind_d  = operation[1:0];
                     busy_d  = 1'b1;
                     state_d = RUN;
                     cnt_d   = early_c ? '0 : (operation[1] ? DIV_LAST : MUL_LAST);
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               hi_d    = res_hi_c;
               lo_d    = res_lo_c;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         kind_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         kind_q  <= kind_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Read port follows the current HI/LO and operation, independent of start/busy
   always_comb begin
      case (operation)
         3'b000:  data_read = hi_q;
         3'b001:  data_read = lo_q;
         default: data_read = '0;
      endcase
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_mdu_responder.sv
// Directed scoreboard bench for mdu_responder; expected HI/LO come from a longint reference model.
module tb_mdu_responder;

   logic        clock;
   logic        reset;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [2:0]  operation;
   logic        start;
   logic        busy;
   logic [31:0] data_read;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;
`ifdef MDU_EARLY_DONE_EN
   localparam int ZDIV_LAT = 1;
   localparam int ZMUL_LAT = 1;
`else
   localparam int ZDIV_LAT = DIV_LAT;
   localparam int ZMUL_LAT = MUL_LAT;
`endif

   mdu_responder #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .operand1  (operand1),
      .operand2  (operand2),
      .operation (operation),
      .start     (start),
      .busy      (busy),
      .data_read (data_read)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sbv, q, r;
      logic [63:0] p;
      e   = '0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         3'b100: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
         3'b101: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'b110: begin
            if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
            else begin q = sa / sbv; r = sa % sbv; e.hi = 32'(r); e.lo = 32'(q); end
         end
         3'b111: begin
            if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
            else begin e.hi = a % b; e.lo = a / b; end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      start     = 1'b0;
      operation = 3'b000;
      #1;
      check({tag, "_hi"}, data_read, ehi);
      operation = 3'b001;
      #1;
      check({tag, "_lo"}, data_read, elo);
   endtask

   // Issue one mul/div; optionally poke a WRITE_LO or pulse reset in a given busy cycle
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int poke_at, input int rst_at);
      int   n;
      exp_t e;
      if (rst_at == 0) sb.push_back(model(op, a, b));
      operation = op;
      operand1  = a;
      operand2  = b;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      operation = 3'b000;
      operand1  = $urandom;
      operand2  = $urandom;
      n = 0;
      while (busy && n < 64) begin
         n++;
         if (n == rst_at) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
            check({tag, "_rst_busy"}, 32'(busy), 32'd0);
            read_hilo({tag, "_rst"}, 32'd0, 32'd0);
            return;
         end
         if (n == poke_at) begin
            start     = 1'b1;
            operation = 3'b011;
            operand1  = 32'h0000_1234;
         end else begin
            start     = 1'b0;
            operation = 3'b000;
         end
         tick();
      end
      check({tag, "_lat"}, 32'(n), 32'(lat));
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s_sb: observed empty queue expected one entry", tag);
      end else begin
         e = sb.pop_front();
         read_hilo(tag, e.hi, e.lo);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      operation = 3'b000;
      operand1  = '0;
      operand2  = '0;
      tick();
      tick();
      reset = 1'b1;
      check("reset_busy", 32'(busy), 32'd0);
      read_hilo("reset", 32'd0, 32'd0);

      run_op("smul",     3'b100, 32'hFFFF_FFFE, 32'd3,          MUL_LAT,  0, 0);
      run_op("umul",     3'b101, 32'hFFFF_FFFF, 32'd2,          MUL_LAT,  0, 0);
      run_op("sdiv",     3'b110, 32'hFFFF_FFF9, 32'd2,          DIV_LAT,  0, 0);
      run_op("sdiv_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  DIV_LAT,  0, 0);
      run_op("sdiv_neg", 3'b110, 32'd7,         32'hFFFF_FFFE,  DIV_LAT,  0, 0);
      run_op("udiv0",    3'b111, 32'd5,         32'd0,          ZDIV_LAT, 0, 0);
      run_op("sdiv0",    3'b110, 32'hFFFF_FFF0, 32'd0,          ZDIV_LAT, 0, 0);
      run_op("umul0",    3'b101, 32'd0,         32'h0000_1234,  ZMUL_LAT, 0, 0);
      run_op("smul_big", 3'b100, 32'h8000_0000, 32'h8000_0000,  MUL_LAT,  0, 0);
      run_op("udiv_poke",3'b111, 32'd100,       32'd7,          DIV_LAT,  3, 0);
      run_op("udiv_rst", 3'b111, 32'd100,       32'd7,          DIV_LAT,  0, 4);

      // Register writes: no busy, readable from the next cycle
      operation = 3'b010;
      operand1  = 32'hDEAD_BEEF;
      start     = 1'b1;
      tick();
      check("wr_hi_busy", 32'(busy), 32'd0);
      check("wr_op_zero", data_read, 32'd0);
      operation = 3'b011;
      operand1  = 32'h0000_0005;
      tick();
      check("wr_lo_busy", 32'(busy), 32'd0);
      read_hilo("wr", 32'hDEAD_BEEF, 32'h0000_0005);

      // Read ops with start do nothing to HI/LO
      operation = 3'b000;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("rd_busy", 32'(busy), 32'd0);
      read_hilo("rd", 32'hDEAD_BEEF, 32'h0000_0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mdu_responder.md
Name: mdu_responder

Overview:
- Responder side of the pipeline's multiply/divide interface.
- The EX stage issues a 3-bit operation plus `start`, and stalls on `busy`. This block latches operands, runs a fixed-latency multiply or divide, and owns the HI/LO registers.
- It returns HI/LO contents to the EX-stage result path for the mfhi/mflo data forwarded into EX/MEM.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- operand1  in  32  rs value (dividend / multiplicand / mthi-mtlo source)
- operand2  in  32  rt value (divisor / multiplier)
- operation  in  3  000 READ_HI, 001 READ_LO, 010 WRITE_HI, 011 WRITE_LO, 100 SMUL, 101 UMUL, 110 SDIV, 111 UDIV
- start  in  1  qualifies operation for one cycle
- busy  out  1  high while an arithmetic operation is in flight
- data_read  out  32  HI when operation=000, LO when 001, else 0

Behaviour:
- Reset (reset==0 at a rising edge): HI=0, LO=0, busy=0, counter=0, latched operands=0, FSM=IDLE. Reset takes priority over everything, including an operation in flight; that operation is abandoned and HI/LO are zeroed.
- data_read is combinational from the current HI/LO and operation. It does not depend on start or busy, so a read issued in the cycle HI/LO commit returns the new value from the next cycle on.
- FSM states: IDLE, RUN.
- IDLE, start=1, op 010: HI <= operand1 at that edge. op 011: LO <= operand1. busy stays 0.
- IDLE, start=1, op 1xx:
  - operand1, operand2 and the op are latched.
  - counter <= latency-1, where latency is MUL_CYCLES for 10x and DIV_CYCLES for 11x.
  - busy <= 1, next state RUN.
- IDLE, start=1, op 000/001: no state change.
- RUN: counter decrements each cycle. When counter==0, HI/LO commit at that edge, busy <= 0 and the FSM returns to IDLE.
- Timing: start sampled at edge t gives busy=1 for exactly latency cycles (edges t+1 .. t+latency). HI/LO are valid and busy=0 after edge t+latency.
- start while busy (any op, including WRITE_HI/WRITE_LO) is ignored. No queueing.
- Operands are captured only at start; later changes on operand1/operand2 have no effect.
- SMUL: {HI,LO} = signed 64-bit product. UMUL: unsigned 64-bit product.
- SDIV:
  - LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- UDIV: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=operand1. Same latency as a normal divide.
- start with an undefined or X operation is treated as a no-op.
- The implementation may use a behavioural * and / evaluated at the commit edge. The latched operands are the only inputs to that evaluation.

Optional Feature:
- Macro MDU_EARLY_DONE_EN.
- When defined:
  - SMUL/UMUL with either latched operand zero, and SDIV/UDIV with divisor zero, complete after exactly 1 busy cycle. Results are identical to the full-latency case.
- When undefined: every mul/div takes the full MUL_CYCLES/DIV_CYCLES.

Test Plan:
- Reset then read: hold reset=0 for 2 edges, release, op=000 then 001 → data_read=0 both; busy=0.
- Signed mult, default params: start op=100, operand1=0xFFFFFFFE (-2), operand2=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult, then signed div:
  - UMUL 0xFFFFFFFF*2 → HI=1, LO=0xFFFFFFFE.
  - Then SDIV -7/2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow and zero divide:
  - SDIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - UDIV 5/0 → LO=0xFFFFFFFF, HI=5. With MDU_EARLY_DONE_EN, busy is high 1 cycle.
- Start while busy and mid-op reset:
  - UDIV 100/7, then in cycle 3 of busy pulse start op=011 operand1=0x1234 → ignored; final LO=14, HI=2.
  - Repeat the divide and assert reset=0 in cycle 4 → busy=0, HI=LO=0 after that edge.
- Write/read path: WRITE_HI 0xDEADBEEF, next cycle READ_HI → data_read=0xDEADBEEF, busy never asserted.
